// File: rtl/mw_ctrl_pkg.sv
// Shared definitions for the Microwatt control register window.
// Register indices are addr[11:2]; responses are AXI4-Lite encodings.
// Pure declarations: no latency or backpressure of its own.
package mw_ctrl_pkg;

    localparam logic [9:0] REG_CTRL      = 10'h000;
    localparam logic [9:0] REG_BOOT_ADDR = 10'h001;
    localparam logic [9:0] REG_STATUS    = 10'h002;
    localparam logic [9:0] REG_SCRATCH   = 10'h003;
    localparam logic [9:0] REG_CYCLE     = 10'h004;

    localparam int CTRL_RUN      = 0;
    localparam int CTRL_SOFT_RST = 1;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [31:0] dat;
        logic [3:0]  strb;
    } wr_hold_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_dat,
                                                input logic [31:0] new_dat,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_dat[8*i +: 8] : old_dat[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/mw_ctrl_rst_gen.sv
// Core reset generator: core_rst = !run or a SOFT_RST hold still counting down.
// Latency: hold counter loads on the pulse edge, core_rst follows run combinationally.
// Backpressure: none; a pulse during an active hold reloads the full count.
module mw_ctrl_rst_gen #(
    parameter int RST_HOLD_CYC = 16
) (
    input  logic aclk,
    input  logic areset,
    input  logic run,
    input  logic soft_rst_pulse,
    output logic core_rst
);

    localparam int CW = $clog2(RST_HOLD_CYC + 1);

    logic [CW-1:0] hold_cnt;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hold_cnt <= '0;
        end else if (soft_rst_pulse) begin
            hold_cnt <= CW'(RST_HOLD_CYC);
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - CW'(1);
        end
    end

    assign core_rst = ~run | (hold_cnt != '0);

endmodule

// File: rtl/mw_ctrl_axil_slave.sv
// AXI4-Lite control window for Microwatt (CTRL, BOOT_ADDR, STATUS, SCRATCH; CYCLE with MW_CTRL_CYCLE_CNT_EN).
// Latency: write commits the edge after AW and W are both held; read data one edge after AR accept.
// Backpressure: one outstanding write and read; AW/W stall while bvalid, AR stalls while rvalid.
module mw_ctrl_axil_slave
    import mw_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int RST_HOLD_CYC = 16
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic                    core_rst,
    output logic [31:0]             boot_addr
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("mw_ctrl_axil_slave supports DATA_WIDTH=32 only");
    end

    logic        rdy_en;
    logic        aw_held;
    logic        w_held;
    logic [9:0]  aw_idx;
    wr_hold_t    w_q;
    logic        run_q;
    logic [31:0] boot_q;
    logic [31:0] scratch_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;

    logic        aw_hs, w_hs, ar_hs;
    logic        wr_commit, soft_rst_pulse, running;
    logic        wr_ok, rd_ok;
    logic [31:0] rd_val;
    logic [9:0]  ar_idx;

`ifdef MW_CTRL_CYCLE_CNT_EN
    logic [31:0] cycle_q;
`endif

    // Readies stay low through reset and for the first edge after release.
    assign s_axi_awready = rdy_en & ~aw_held & ~bvalid_q;
    assign s_axi_wready  = rdy_en & ~w_held & ~bvalid_q;
    assign s_axi_arready = rdy_en & ~rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign boot_addr     = boot_q;

    assign aw_hs     = s_axi_awvalid & s_axi_awready;
    assign w_hs      = s_axi_wvalid & s_axi_wready;
    assign ar_hs     = s_axi_arvalid & s_axi_arready;
    assign ar_idx    = s_axi_araddr[11:2];
    assign wr_commit = aw_held & w_held;
    assign running   = run_q & ~core_rst;

    assign soft_rst_pulse = wr_commit & (aw_idx == REG_CTRL) & w_q.strb[0]
                          & w_q.dat[CTRL_SOFT_RST];

    always_comb begin
        wr_ok = 1'b0;
        case (aw_idx)
            REG_CTRL, REG_BOOT_ADDR, REG_STATUS, REG_SCRATCH: wr_ok = 1'b1;
`ifdef MW_CTRL_CYCLE_CNT_EN
            REG_CYCLE: wr_ok = 1'b1;
`endif
            default: wr_ok = 1'b0;
        endcase
    end

    always_comb begin
        rd_ok  = 1'b1;
        rd_val = '0;
        case (ar_idx)
            REG_CTRL:      rd_val = {31'b0, run_q};
            REG_BOOT_ADDR: rd_val = boot_q;
            REG_STATUS:    rd_val = {30'b0, core_rst, running};
            REG_SCRATCH:   rd_val = scratch_q;
`ifdef MW_CTRL_CYCLE_CNT_EN
            REG_CYCLE:     rd_val = cycle_q;
`endif
            default:       rd_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rdy_en   <= 1'b0;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_idx   <= '0;
            w_q      <= '0;
            bvalid_q <= 1'b0;
            bresp_q  <= AXI_RESP_OKAY;
        end else begin
            rdy_en <= 1'b1;
            if (wr_commit) begin
                aw_held <= 1'b0;
            end else if (aw_hs) begin
                aw_held <= 1'b1;
                aw_idx  <= s_axi_awaddr[11:2];
            end
            if (wr_commit) begin
                w_held <= 1'b0;
            end else if (w_hs) begin
                w_held <= 1'b1;
                w_q    <= '{dat: s_axi_wdata, strb: s_axi_wstrb};
            end
            if (wr_commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;
            end else if (s_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Registers update on the same edge the read data is captured, so a
    // coincident read sees the pre-write value.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            run_q     <= 1'b0;
            boot_q    <= '0;
            scratch_q <= '0;
        end else if (wr_commit) begin
            case (aw_idx)
                REG_CTRL:      if (w_q.strb[0]) run_q <= w_q.dat[CTRL_RUN];
                REG_BOOT_ADDR: boot_q    <= apply_wstrb(boot_q, w_q.dat, w_q.strb);
                REG_SCRATCH:   scratch_q <= apply_wstrb(scratch_q, w_q.dat, w_q.strb);
                default: ;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= AXI_RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
            rresp_q  <= rd_ok ? AXI_RESP_OKAY : AXI_RESP_DECERR;
        end else if (s_axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

`ifdef MW_CTRL_CYCLE_CNT_EN
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cycle_q <= '0;
        end else if (soft_rst_pulse) begin
            cycle_q <= '0;
        end else if (running) begin
            cycle_q <= cycle_q + 32'd1;
        end
    end
`endif

    mw_ctrl_rst_gen #(
        .RST_HOLD_CYC(RST_HOLD_CYC)
    ) u_rst_gen (
        .aclk          (aclk),
        .areset        (areset),
        .run           (run_q),
        .soft_rst_pulse(soft_rst_pulse),
        .core_rst      (core_rst)
    );

    logic unused_ok;
    assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[ADDR_WIDTH-1:12], s_axi_awaddr[1:0],
                         s_axi_araddr[ADDR_WIDTH-1:12], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_mw_ctrl_axil_slave.sv
// Directed bench for mw_ctrl_axil_slave: reset, boot/run, split write, wstrb, soft reset, decode errors.
module tb_mw_ctrl_axil_slave;

    localparam int RST_HOLD = 16;
    localparam int TMO      = 50;

    logic        aclk;
    logic        areset;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        core_rst;
    logic [31:0] boot_addr;

    int n_cmp = 0;
    int n_err = 0;

    logic mon_clr;
    int   rst_hi;

    mw_ctrl_axil_slave #(
        .ADDR_WIDTH  (32),
        .DATA_WIDTH  (32),
        .RST_HOLD_CYC(RST_HOLD)
    ) dut (
        .aclk         (aclk),
        .areset       (areset),
        .s_axi_awaddr (awaddr),
        .s_axi_awprot (3'b000),
        .s_axi_awvalid(awvalid),
        .s_axi_awready(awready),
        .s_axi_wdata  (wdata),
        .s_axi_wstrb  (wstrb),
        .s_axi_wvalid (wvalid),
        .s_axi_wready (wready),
        .s_axi_bresp  (bresp),
        .s_axi_bvalid (bvalid),
        .s_axi_bready (bready),
        .s_axi_araddr (araddr),
        .s_axi_arprot (3'b000),
        .s_axi_arvalid(arvalid),
        .s_axi_arready(arready),
        .s_axi_rdata  (rdata),
        .s_axi_rresp  (rresp),
        .s_axi_rvalid (rvalid),
        .s_axi_rready (rready),
        .core_rst     (core_rst),
        .boot_addr    (boot_addr)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Counts negedges with core_rst high since the last clear.
    always @(negedge aclk) begin
        if (mon_clr) rst_hi <= 0;
        else if (core_rst) rst_hi <= rst_hi + 1;
    end

    // All tasks are entered and left #1 after a rising edge.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        int n = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        while (!(aw_done && w_done) && n < TMO) begin
            aw_now = awvalid && awready;
            w_now  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_now) begin aw_done = 1; awvalid = 1'b0; end
            if (w_now)  begin w_done = 1;  wvalid  = 1'b0; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        bready = 1'b1;
        n = 0;
        while (!bvalid && n < TMO) begin @(posedge aclk); #1; n++; end
        resp = bresp;
        if (!bvalid) begin
            n_cmp++; n_err++;
            $display("FAIL write_timeout addr=%h: bvalid=%b required 1", a, bvalid);
            resp = 2'bxx;
        end
        @(posedge aclk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
        int n = 0;
        araddr = a; arvalid = 1'b1;
        while (!arready && n < TMO) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        arvalid = 1'b0;
        rready = 1'b1;
        n = 0;
        while (!rvalid && n < TMO) begin @(posedge aclk); #1; n++; end
        d = rdata; resp = rresp;
        if (!rvalid) begin
            n_cmp++; n_err++;
            $display("FAIL read_timeout addr=%h: rvalid=%b required 1", a, rvalid);
            d = 'x;
        end
        @(posedge aclk); #1;
        rready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        areset = 1'b1;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0;
        mon_clr = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        n_cmp++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_handshake: aw/w/ar/b/r=%b required 00000",
                     {awready, wready, arready, bvalid, rvalid});
        end
        n_cmp++;
        if (core_rst !== 1'b1 || boot_addr !== 32'h0 || rdata !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: core_rst=%b boot_addr=%h rdata=%h required 1/0/0",
                     core_rst, boot_addr, rdata);
        end
        areset = 1'b0;
        @(posedge aclk); #1;
        axi_read(32'hA000_0008, d, r);
        n_cmp++;
        if (d !== 32'h2 || r !== 2'b00) begin
            n_err++;
            $display("FAIL reset_status: got %h/%b required 00000002/00", d, r);
        end
    endtask

    task automatic test_boot_run();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'hA000_0004, 32'h2000_0000, 4'hF, r);
        n_cmp++;
        if (r !== 2'b00 || boot_addr !== 32'h2000_0000) begin
            n_err++;
            $display("FAIL boot_addr: bresp=%b boot_addr=%h required 00/20000000", r, boot_addr);
        end
        axi_write(32'hA000_0000, 32'h1, 4'hF, r);
        n_cmp++;
        if (core_rst !== 1'b0) begin
            n_err++;
            $display("FAIL run_core_rst: core_rst=%b required 0", core_rst);
        end
        axi_read(32'hA000_0008, d, r);
        n_cmp++;
        if (d !== 32'h1 || r !== 2'b00) begin
            n_err++;
            $display("FAIL run_status: got %h/%b required 00000001/00", d, r);
        end
    endtask

    task automatic test_split_write();
        logic [31:0] d;
        logic [1:0]  r;
        bit bad;
        awaddr = 32'h0000_000C; awvalid = 1'b1; wvalid = 1'b0;
        wdata = 32'h1234_5678; wstrb = 4'hF;
        n_cmp++;
        if (awready !== 1'b1) begin
            n_err++;
            $display("FAIL split_awready: awready=%b required 1", awready);
        end
        @(posedge aclk); #1;
        awvalid = 1'b0;
        bad = 0;
        repeat (2) begin
            @(posedge aclk); #1;
            if (awready !== 1'b0 || bvalid !== 1'b0) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL split_aw_held: awready=%b bvalid=%b required 0/0", awready, bvalid);
        end
        wvalid = 1'b1;
        @(posedge aclk); #1;
        wvalid = 1'b0;
        n_cmp++;
        if (bvalid !== 1'b0) begin
            n_err++;
            $display("FAIL split_early_b: bvalid=%b required 0", bvalid);
        end
        @(posedge aclk); #1;
        n_cmp++;
        if (bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_err++;
            $display("FAIL split_commit: bvalid=%b bresp=%b required 1/00", bvalid, bresp);
        end
        bad = 0;
        repeat (5) begin
            @(posedge aclk); #1;
            if (bvalid !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) bad = 1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL split_b_stall: bvalid=%b awready=%b wready=%b required 1/0/0",
                     bvalid, awready, wready);
        end
        bready = 1'b1;
        @(posedge aclk); #1;
        bready = 1'b0;
        bad = 0;
        repeat (3) begin
            if (bvalid !== 1'b0) bad = 1;
            @(posedge aclk); #1;
        end
        n_cmp++;
        if (bad) begin
            n_err++;
            $display("FAIL split_single_b: bvalid=%b required 0 after handshake", bvalid);
        end
        axi_read(32'h0000_000C, d, r);
        n_cmp++;
        if (d !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL split_data: got %h required 12345678", d);
        end
    endtask

    task automatic test_wstrb();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(32'h0000_000C, 32'h0, 4'hF, r);
        axi_write(32'h0000_000C, 32'hDEAD_BEEF, 4'h3, r);
        axi_read(32'h0000_000C, d, r);
        n_cmp++;
        if (d !== 32'h0000_BEEF || r !== 2'b00) begin
            n_err++;
            $display("FAIL wstrb_scratch: got %h/%b required 0000BEEF/00", d, r);
        end
        axi_write(32'h0000_0004, 32'h1111_2222, 4'hC, r);
        n_cmp++;
        if (boot_addr !== 32'h1111_0000) begin
            n_err++;
            $display("FAIL wstrb_boot: boot_addr=%h required 11110000", boot_addr);
        end
        axi_write(32'h0000_0004, 32'h2000_0000, 4'hF, r);
        axi_write(32'h0000_0000, 32'h3, 4'h2, r);
        n_cmp++;
        if (core_rst !== 1'b0) begin
            n_err++;
            $display("FAIL wstrb_no_soft_rst: core_rst=%b required 0", core_rst);
        end
    endtask

    task automatic test_soft_rst();
        logic [31:0] d;
        logic [1:0]  r;
        int n;
        mon_clr = 1'b1;
        @(posedge aclk); #1;
        mon_clr = 1'b0;
        axi_write(32'h0000_0000, 32'h3, 4'hF, r);
        n = 0;
        while (core_rst && n < 4 * RST_HOLD) begin @(posedge aclk); #1; n++; end
        @(posedge aclk); #1;
        n_cmp++;
        if (core_rst !== 1'b0 || rst_hi != RST_HOLD) begin
            n_err++;
            $display("FAIL soft_rst_hold: core_rst=%b high_cycles=%0d required 0/%0d",
                     core_rst, rst_hi, RST_HOLD);
        end
        axi_read(32'h0000_0000, d, r);
        n_cmp++;
        if (d !== 32'h1 || r !== 2'b00) begin
            n_err++;
            $display("FAIL soft_rst_ctrl: got %h/%b required 00000001/00", d, r);
        end
        axi_write(32'h0000_0000, 32'h0, 4'hF, r);
        axi_read(32'h0000_0008, d, r);
        n_cmp++;
        if (core_rst !== 1'b1 || d !== 32'h2) begin
            n_err++;
            $display("FAIL run_clear: core_rst=%b status=%h required 1/00000002", core_rst, d);
        end
        axi_write(32'h0000_0000, 32'h1, 4'hF, r);
    endtask

    task automatic test_decode();
        logic [31:0] d, c1, c2;
        logic [1:0]  r, r1, r2;
        axi_read(32'h0000_0020, d, r);
        n_cmp++;
        if (d !== 32'h0 || r !== 2'b11) begin
            n_err++;
            $display("FAIL decerr_read: got %h/%b required 00000000/11", d, r);
        end
        axi_write(32'h0000_0020, 32'hFFFF_FFFF, 4'hF, r);
        n_cmp++;
        if (r !== 2'b11) begin
            n_err++;
            $display("FAIL decerr_write: bresp=%b required 11", r);
        end
        axi_write(32'h0000_0008, 32'hFFFF_FFFF, 4'hF, r);
        axi_read(32'h0000_0008, d, r1);
        n_cmp++;
        if (r !== 2'b00 || d !== 32'h1 || r1 !== 2'b00) begin
            n_err++;
            $display("FAIL status_ro: bresp=%b status=%h required 00/00000001", r, d);
        end
        axi_read(32'hA000_0004, d, r);
        n_cmp++;
        if (d !== 32'h2000_0000) begin
            n_err++;
            $display("FAIL upper_addr_ignored: got %h required 20000000", d);
        end
        axi_read(32'h0000_0010, c1, r1);
        axi_read(32'h0000_0010, c2, r2);
`ifdef MW_CTRL_CYCLE_CNT_EN
        n_cmp++;
        if (r1 !== 2'b00 || r2 !== 2'b00 || !(c2 > c1) || (c2 - c1) > 32'd10) begin
            n_err++;
            $display("FAIL cycle_count: reads %h then %h resp %b/%b required increasing OKAY",
                     c1, c2, r1, r2);
        end
`else
        n_cmp++;
        if (r1 !== 2'b11 || c1 !== 32'h0) begin
            n_err++;
            $display("FAIL cycle_hole: got %h/%b required 00000000/11", c1, r1);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_boot_run();
        test_split_write();
        test_wstrb();
        test_soft_rst();
        test_decode();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
